// File: rtl/tt_sel_pkg.sv
// Shared constants, state encoding and width helper for the project-select controller.
// Used by tt_sel_sync and tt_proj_sel.
package tt_sel_pkg;

  localparam int unsigned G_X = 16;
  localparam int unsigned G_Y = 24;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SWITCH = 2'd1;
  localparam state_t ST_HOLD   = 2'd2;
  localparam state_t ST_RUN    = 2'd3;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/tt_sel_sync.sv
// Optional 2-flop synchronizer (TT_SEL_SYNC_EN) followed by a rising-edge detector.
// Edges are suppressed until the pipeline has refilled after reset, so a pad already high
// at reset release needs a fresh low-to-high transition to register.
module tt_sel_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

`ifdef TT_SEL_SYNC_EN
  localparam logic [1:0] ARM_CYC = 2'd3;

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], din};
    end
  end

  assign level = sync_q[1];
`else
  localparam logic [1:0] ARM_CYC = 2'd1;

  assign level = din;
`endif

  logic       prev_q;
  logic [1:0] arm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      prev_q <= level;
      if (arm_q != ARM_CYC) arm_q <= arm_q + 2'd1;
    end
  end

  assign rise = level & ~prev_q & (arm_q == ARM_CYC);

endmodule

// File: rtl/tt_proj_sel.sv
// Project-select controller: registered tile address plus break-before-make enable/reset
// sequencing. Define TT_SEL_SYNC_EN to synchronize the three control pads internally.
module tt_proj_sel #(
  parameter  int unsigned G_X     = tt_sel_pkg::G_X,
  parameter  int unsigned G_Y     = tt_sel_pkg::G_Y,
  parameter  int unsigned RST_CYC = 4,
  localparam int unsigned N_TILE  = G_X * G_Y,
  localparam int unsigned ADDR_W  = tt_sel_pkg::clog2(N_TILE),
  localparam int unsigned X_W     = tt_sel_pkg::clog2(G_X),
  localparam int unsigned Y_W     = tt_sel_pkg::clog2(G_Y)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_inc,
  input  logic              sel_clr,
  input  logic              sel_ena,
  output logic [ADDR_W-1:0] addr,
  output logic [X_W-1:0]    addr_x,
  output logic [Y_W-1:0]    addr_y,
  output logic              proj_ena,
  output logic              proj_rst,
  output logic              busy
);
  import tt_sel_pkg::*;

  localparam int unsigned       CNT_W    = clog2(RST_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RST_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(N_TILE - 1);
  localparam logic [X_W-1:0]    X_MAX    = X_W'(G_X - 1);
  localparam logic [Y_W-1:0]    Y_MAX    = Y_W'(G_Y - 1);

  logic inc_rise, clr_rise, ena_rise, ena_lvl;
  logic inc_lvl, clr_lvl;

  tt_sel_sync u_sync_inc (
    .clk   (clk),
    .rst   (rst),
    .din   (sel_inc),
    .level (inc_lvl),
    .rise  (inc_rise)
  );

  tt_sel_sync u_sync_clr (
    .clk   (clk),
    .rst   (rst),
    .din   (sel_clr),
    .level (clr_lvl),
    .rise  (clr_rise)
  );

  tt_sel_sync u_sync_ena (
    .clk   (clk),
    .rst   (rst),
    .din   (sel_ena),
    .level (ena_lvl),
    .rise  (ena_rise)
  );

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              proj_ena_q, proj_rst_q, busy_q;
  logic              chg;

  assign chg = inc_rise | clr_rise;

  // Column/row tracked alongside the flat index so no divider is needed.
  always_comb begin
    addr_d = addr_q;
    x_d    = x_q;
    y_d    = y_q;
    if (clr_rise) begin
      addr_d = '0;
      x_d    = '0;
      y_d    = '0;
    end else if (inc_rise) begin
      addr_d = (addr_q == ADDR_MAX) ? '0 : addr_q + ADDR_W'(1);
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!ena_lvl) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ena_rise) state_d = ST_SWITCH;
        end
        ST_SWITCH: begin
          if (!chg) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_HOLD: begin
          if (chg) begin
            state_d = ST_SWITCH;
          end else if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (chg) state_d = ST_SWITCH;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from next state so every output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      proj_ena_q <= 1'b0;
      proj_rst_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      proj_ena_q <= (state_d == ST_HOLD) || (state_d == ST_RUN);
      proj_rst_q <= (state_d != ST_RUN);
      busy_q     <= (state_d == ST_SWITCH) || (state_d == ST_HOLD);
    end
  end

  assign addr     = addr_q;
  assign addr_x   = x_q;
  assign addr_y   = y_q;
  assign proj_ena = proj_ena_q;
  assign proj_rst = proj_rst_q;
  assign busy     = busy_q;

  logic unused_lvl;
  assign unused_lvl = inc_lvl ^ clr_lvl;

endmodule

// File: tb/tb_tt_proj_sel.sv
// Self-checking bench for tt_proj_sel: directed scenarios plus random pad activity,
// compared against a cycle-level behavioural model (address arithmetic + sequence phase).
module tb_tt_proj_sel;

  localparam int unsigned G_X     = 16;
  localparam int unsigned G_Y     = 24;
  localparam int unsigned RST_CYC = 4;
  localparam int unsigned N_TILE  = G_X * G_Y;
`ifdef TT_SEL_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel_inc = 1'b0;
  logic       sel_clr = 1'b0;
  logic       sel_ena = 1'b0;
  logic [8:0] addr;
  logic [3:0] addr_x;
  logic [4:0] addr_y;
  logic       proj_ena, proj_rst, busy;

  tt_proj_sel #(
    .G_X     (G_X),
    .G_Y     (G_Y),
    .RST_CYC (RST_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel_inc  (sel_inc),
    .sel_clr  (sel_clr),
    .sel_ena  (sel_ena),
    .addr     (addr),
    .addr_x   (addr_x),
    .addr_y   (addr_y),
    .proj_ena (proj_ena),
    .proj_rst (proj_rst),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_low = 0;
  int n_high = 0;

  // Reference model state: flat address, active flag, cycles since (re)start of sequence.
  int       m_addr;
  bit       m_act;
  int       m_phase;
  bit [2:0] m_hist;
  bit [2:0] m_d1, m_d2;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr  = 0;
    m_act   = 1'b0;
    m_phase = 0;
    m_hist  = 3'b111;
    m_d1    = {sel_ena, sel_clr, sel_inc};
    m_d2    = m_d1;
  endtask

  task automatic model_step();
    bit [2:0] pad, lv, rise;
    pad = {sel_ena, sel_clr, sel_inc};
`ifdef TT_SEL_SYNC_EN
    lv   = m_d2;
    m_d2 = m_d1;
    m_d1 = pad;
`else
    lv = pad;
`endif
    rise   = lv & ~m_hist;
    m_hist = lv;
    if (rise[1]) m_addr = 0;
    else if (rise[0]) m_addr = (m_addr + 1) % N_TILE;
    if (!lv[2]) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (rise[2]) begin
        m_act   = 1'b1;
        m_phase = 0;
      end
    end else if (rise[1] || rise[0]) begin
      m_phase = 0;
    end else if (m_phase <= RST_CYC) begin
      m_phase++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("addr", 32'(addr), m_addr);
    check_val("addr_x", 32'(addr_x), m_addr % G_X);
    check_val("addr_y", 32'(addr_y), m_addr / G_X);
    check_val("proj_ena", 32'(proj_ena), (m_act && m_phase >= 1) ? 1 : 0);
    check_val("proj_rst", 32'(proj_rst), (m_act && m_phase > RST_CYC) ? 0 : 1);
    check_val("busy", 32'(busy), (m_act && m_phase <= RST_CYC) ? 1 : 0);
    if (proj_ena) n_high++;
    else n_low++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_inc();
    sel_inc = 1'b1;
    tick();
    sel_inc = 1'b0;
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_addr"}, 32'(addr), 0);
    check_val({tag, "_ax"}, 32'(addr_x), 0);
    check_val({tag, "_ay"}, 32'(addr_y), 0);
    check_val({tag, "_ena"}, 32'(proj_ena), 0);
    check_val({tag, "_rst"}, 32'(proj_rst), 1);
    check_val({tag, "_busy"}, 32'(busy), 0);
  endtask

  int en_lat, rs_lat, a0;

  initial begin
    // Power-on reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst = 1'b0;
    model_reset();
    ticks(4);

    // Enable from IDLE: latency of enable and of reset release
    sel_ena = 1'b1;
    en_lat = -1;
    rs_lat = -1;
    for (int t = 1; t <= 40 && rs_lat < 0; t++) begin
      tick();
      if (en_lat < 0 && proj_ena) en_lat = t;
      if (rs_lat < 0 && !proj_rst) rs_lat = t;
    end
    check_val("ena_latency", en_lat, 2 + DLY);
    check_val("rst_latency", rs_lat, 2 + RST_CYC + DLY);
    check_val("run_busy", 32'(busy), 0);
    check_val("run_addr", 32'(addr), 0);

    // 17 increments: one enable-low cycle per pulse
    n_low = 0;
    for (int i = 0; i < 17; i++) pulse_inc();
    ticks(4);
    check_val("inc17_low_cycles", n_low, 17);
    ticks(RST_CYC + 4);
    check_val("inc17_addr", 32'(addr), 17);
    check_val("inc17_x", 32'(addr_x), 1);
    check_val("inc17_y", 32'(addr_y), 1);

    // Clear then a full lap of the grid
    sel_clr = 1'b1;
    tick();
    sel_clr = 1'b0;
    ticks(4);
    for (int i = 0; i < 384; i++) pulse_inc();
    ticks(4);
    check_val("wrap_addr", 32'(addr), 0);
    check_val("wrap_x", 32'(addr_x), 0);
    check_val("wrap_y", 32'(addr_y), 0);

    // Clear beats increment in the same cycle
    for (int i = 0; i < 5; i++) pulse_inc();
    ticks(2);
    check_val("pre_prio_addr", 32'(addr), 5);
    sel_inc = 1'b1;
    sel_clr = 1'b1;
    tick();
    sel_inc = 1'b0;
    sel_clr = 1'b0;
    ticks(DLY);
    check_val("clr_prio_addr", 32'(addr), 0);

    // Disable while in HOLD
    ticks(RST_CYC + 6);
    sel_inc = 1'b1;
    tick();
    sel_inc = 1'b0;
    ticks(1 + DLY);
    check_val("hold_busy", 32'(busy), 1);
    check_val("hold_ena", 32'(proj_ena), 1);
    sel_ena = 1'b0;
    ticks(1 + DLY);
    check_val("dis_ena", 32'(proj_ena), 0);
    check_val("dis_rst", 32'(proj_rst), 1);
    check_val("dis_busy", 32'(busy), 0);

    // Increments while idle move the address but never enable
    a0 = int'(addr);
    n_high = 0;
    for (int i = 0; i < 3; i++) pulse_inc();
    ticks(2);
    check_val("idle_addr", 32'(addr), (a0 + 3) % N_TILE);
    check_val("idle_ena_cycles", n_high, 0);

    // Async reset in RUN, then no start while enable is held high
    sel_ena = 1'b1;
    ticks(RST_CYC + 4 + DLY);
    check_val("pre_arst_rst", 32'(proj_rst), 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("arst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    ticks(6);
    check_val("held_ena_no_start", 32'(proj_ena), 0);
    sel_ena = 1'b0;
    ticks(3);
    sel_ena = 1'b1;
    ticks(RST_CYC + 4 + DLY);
    check_val("restart_run", 32'(proj_rst), 0);

    // Random pad activity
    for (int i = 0; i < 400; i++) begin
      sel_inc = ($urandom_range(0, 2) == 0);
      sel_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) sel_ena = ~sel_ena;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
